bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Values above 999999 saturate to 24'h999999 and set OVF/DP_OUT for the display.
module bin_to_bcd_seq #(
  parameter int BIN_W = 20
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [BIN_W-1:0] BIN_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [23:0]      BCD_OUT,
  output logic             OVF,
  output logic [7:0]       DP_OUT
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_SHIFT = 2'd1;
  localparam logic [1:0]  ST_DONE  = 2'd2;
  localparam logic [4:0]  CNT_LOAD = 5'(BIN_W);
  localparam logic [31:0] BCD_MAX  = 32'd999999;

  logic [1:0]       state_reg;
  logic [4:0]       cnt_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [23:0]      scratch_reg;
  logic             ovf_flag_reg;
  logic [23:0]      bcd_reg;
  logic             ovf_reg;
  logic             done_reg;
  logic [7:0]       dp_reg;

  logic [23:0]      adj;
  logic [31:0]      bin_ext;
  logic             in_ovf;

  assign bin_ext = 32'(BIN_IN);
  assign in_ovf  = (bin_ext > BCD_MAX);

  // Add-3 correction on every scratch digit before the shift.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                              (scratch_reg[gi*4 +: 4] + 4'd3) :
                              scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      bin_reg      <= '0;
      scratch_reg  <= '0;
      ovf_flag_reg <= 1'b0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
      done_reg     <= 1'b0;
      dp_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            bin_reg      <= BIN_IN;
            scratch_reg  <= '0;
            cnt_reg      <= CNT_LOAD;
            ovf_flag_reg <= in_ovf;
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_reg <= {adj[22:0], bin_reg[BIN_W-1]};
          bin_reg     <= {bin_reg[BIN_W-2:0], 1'b0};
          cnt_reg     <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Outputs are registered here so DONE and BCD_OUT appear together.
          bcd_reg   <= ovf_flag_reg ? 24'h999999 : scratch_reg;
          ovf_reg   <= ovf_flag_reg;
          dp_reg    <= ovf_flag_reg ? 8'h3F : 8'h00;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY    = (state_reg != ST_IDLE);
  assign DONE    = done_reg;
  assign BCD_OUT = bcd_reg;
  assign OVF     = ovf_reg;
  assign DP_OUT  = dp_reg;

endmodule
